// File: rtl/vend_session_ctrl.sv
// Vending session FSM: collect coins, dispense, return change; all outputs registered, 1-cycle decisions.
// dispense/change requests held until handshake; per-product sales counters when VEND_SESSION_CTRL_SALES_CNT_EN.
module vend_session_ctrl #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        product_valid,
  input  logic [1:0]  product,
  input  logic        coin_valid,
  input  logic [2:0]  coin_val,
  output logic        coin_ready,
  input  logic        cancel,
  output logic        dispense,
  output logic [1:0]  dispense_id,
  input  logic        dispense_ready,
  output logic        change_valid,
  output logic [3:0]  change_amt,
  input  logic        change_ack,
  output logic [3:0]  credit,
  output logic        busy,
  output logic [31:0] sales_cnt
);

  typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state, state_nxt;
  logic [1:0]  sel, sel_nxt;
  logic [3:0]  credit_nxt, change_amt_nxt, credit_upd;
  logic [15:0] timer, timer_nxt;
  logic        dispense_nxt, change_valid_nxt;
  logic [1:0]  dispense_id_nxt;
  logic        coin_nz, abort, disp_hs;

  function automatic logic [3:0] price(input logic [1:0] p);
    case (p)
      2'd0:    price = 4'd3;
      2'd1:    price = 4'd5;
      2'd2:    price = 4'd6;
      default: price = 4'd7;
    endcase
  endfunction

  always_comb begin
    state_nxt        = state;
    sel_nxt          = sel;
    credit_nxt       = credit;
    timer_nxt        = timer;
    dispense_nxt     = dispense;
    dispense_id_nxt  = dispense_id;
    change_valid_nxt = change_valid;
    change_amt_nxt   = change_amt;
    coin_nz    = coin_valid && coin_ready && (coin_val != 3'd0);
    credit_upd = credit + (coin_nz ? {1'b0, coin_val} : 4'd0);
    // a zero-value coin neither adds credit nor counts as activity
    abort      = cancel || (!coin_nz && (timer == TIMER_LAST));
    disp_hs    = dispense && dispense_ready;
    case (state)
      IDLE: begin
        if (product_valid) begin
          state_nxt  = COLLECT;
          sel_nxt    = product;
          credit_nxt = 4'd0;
          timer_nxt  = 16'd0;
        end
      end
      COLLECT: begin
        credit_nxt = credit_upd;
        if (abort) begin
          if (credit_upd != 4'd0) begin
            state_nxt        = CHANGE;
            change_valid_nxt = 1'b1;
            change_amt_nxt   = credit_upd;
          end else begin
            state_nxt = IDLE;
          end
        end else if (credit_upd >= price(sel)) begin
          state_nxt       = DISPENSE;
          dispense_nxt    = 1'b1;
          dispense_id_nxt = sel;
        end else begin
          timer_nxt = coin_nz ? 16'd0 : timer + 16'd1;
        end
      end
      DISPENSE: begin
        if (disp_hs) begin
          dispense_nxt = 1'b0;
          if (credit != price(sel)) begin
            state_nxt        = CHANGE;
            change_valid_nxt = 1'b1;
            change_amt_nxt   = credit - price(sel);
          end else begin
            state_nxt  = IDLE;
            credit_nxt = 4'd0;
          end
        end
      end
      CHANGE: begin
        if (change_valid && change_ack) begin
          state_nxt        = IDLE;
          change_valid_nxt = 1'b0;
          change_amt_nxt   = 4'd0;
          credit_nxt       = 4'd0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sel          <= 2'd0;
      credit       <= 4'd0;
      timer        <= 16'd0;
      dispense     <= 1'b0;
      dispense_id  <= 2'd0;
      change_valid <= 1'b0;
      change_amt   <= 4'd0;
      coin_ready   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      sel          <= sel_nxt;
      credit       <= credit_nxt;
      timer        <= timer_nxt;
      dispense     <= dispense_nxt;
      dispense_id  <= dispense_id_nxt;
      change_valid <= change_valid_nxt;
      change_amt   <= change_amt_nxt;
      coin_ready   <= (state_nxt == COLLECT);
      busy         <= (state_nxt != IDLE);
    end
  end

`ifdef VEND_SESSION_CTRL_SALES_CNT_EN
  logic [7:0] sales [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) sales[i] <= 8'd0;
    end else if (disp_hs && (sales[dispense_id] != 8'hff)) begin
      sales[dispense_id] <= sales[dispense_id] + 8'd1;
    end
  end

  assign sales_cnt = {sales[3], sales[2], sales[1], sales[0]};
`else
  assign sales_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_vend_session_ctrl.sv
// Self-checking bench for vend_session_ctrl: directed vectors, hand sequences, random run vs session model.
module tb_vend_session_ctrl;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        product_valid = 1'b0;
  logic [1:0]  product = 2'd0;
  logic        coin_valid = 1'b0;
  logic [2:0]  coin_val = 3'd0;
  logic        coin_ready;
  logic        cancel = 1'b0;
  logic        dispense;
  logic [1:0]  dispense_id;
  logic        dispense_ready = 1'b0;
  logic        change_valid;
  logic [3:0]  change_amt;
  logic        change_ack = 1'b0;
  logic [3:0]  credit;
  logic        busy;
  logic [31:0] sales_cnt;

  vend_session_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .product_valid(product_valid), .product(product),
    .coin_valid(coin_valid), .coin_val(coin_val), .coin_ready(coin_ready),
    .cancel(cancel), .dispense(dispense), .dispense_id(dispense_id),
    .dispense_ready(dispense_ready), .change_valid(change_valid),
    .change_amt(change_amt), .change_ack(change_ack), .credit(credit),
    .busy(busy), .sales_cnt(sales_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Session-level model: what the machine owes the customer, not how it encodes it.
  bit m_active, m_owe_prod;
  int m_sel, m_credit, m_idle, m_owe_chg;
  int m_sales[4];

  function automatic int price_of(input int p);
    return (p == 0) ? 3 : (p == 1) ? 5 : (p == 2) ? 6 : 7;
  endfunction

  task automatic model_step();
    int c;
    bit got, stop;
    if (rst) begin
      m_active = 0; m_owe_prod = 0; m_owe_chg = 0;
      m_sel = 0; m_credit = 0; m_idle = 0;
      for (int i = 0; i < 4; i++) m_sales[i] = 0;
    end else if (!m_active) begin
      if (product_valid) begin
        m_active = 1; m_sel = int'(product); m_credit = 0; m_idle = 0;
      end
    end else if (m_owe_prod) begin
      if (dispense_ready) begin
        m_owe_prod = 0;
        if (m_sales[m_sel] < 255) m_sales[m_sel]++;
        if (m_credit > price_of(m_sel)) m_owe_chg = m_credit - price_of(m_sel);
        else begin m_active = 0; m_credit = 0; end
      end
    end else if (m_owe_chg > 0) begin
      if (change_ack) begin m_owe_chg = 0; m_active = 0; m_credit = 0; end
    end else begin
      got  = coin_valid && (coin_val != 3'd0);
      c    = m_credit + (got ? int'(coin_val) : 0);
      stop = cancel || (!got && m_idle == TO - 1);
      m_credit = c;
      if (stop) begin
        if (c > 0) m_owe_chg = c;
        else m_active = 0;
      end else if (c >= price_of(m_sel)) begin
        m_owe_prod = 1;
      end else begin
        m_idle = got ? 0 : m_idle + 1;
      end
    end
  endtask

  function automatic logic [31:0] exp_sales();
    logic [31:0] r;
    r = 32'd0;
`ifdef VEND_SESSION_CTRL_SALES_CNT_EN
    for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'(m_sales[i]);
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_disp"}, 32'(dispense), 32'(m_owe_prod));
    if (m_owe_prod) chk({tag, "_id"}, 32'(dispense_id), 32'(m_sel));
    chk({tag, "_chv"}, 32'(change_valid), 32'(m_owe_chg > 0));
    if (m_owe_chg > 0) chk({tag, "_amt"}, 32'(change_amt), 32'(m_owe_chg));
    chk({tag, "_credit"}, 32'(credit), 32'(m_credit));
    chk({tag, "_busy"}, 32'(busy), 32'(m_active));
    chk({tag, "_crdy"}, 32'(coin_ready), 32'(m_active && !m_owe_prod && m_owe_chg == 0));
    chk({tag, "_sales"}, sales_cnt, exp_sales());
  endtask

  task automatic apply(input logic r, input logic pv, input logic [1:0] pr, input logic cv,
                       input logic [2:0] cval, input logic cn, input logic dr, input logic ca);
    rst = r; product_valid = pv; product = pr; coin_valid = cv; coin_val = cval;
    cancel = cn; dispense_ready = dr; change_ack = ca;
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic       rst, pv;
    logic [1:0] prod;
    logic       cv;
    logic [2:0] cval;
    logic       cn, dr, ca;
    logic       disp;
    logic [1:0] id;
    logic       chv;
    logic [3:0] amt, cred;
    logic       busy, crdy;
  } vec_t;

  function automatic vec_t mk(input logic r, pv, input logic [1:0] pr, input logic cv,
                              input logic [2:0] cval, input logic cn, dr, ca, d,
                              input logic [1:0] id, input logic chv, input logic [3:0] amt,
                              input logic [3:0] cred, input logic b, crdy);
    vec_t v;
    v.rst = r; v.pv = pv; v.prod = pr; v.cv = cv; v.cval = cval; v.cn = cn; v.dr = dr; v.ca = ca;
    v.disp = d; v.id = id; v.chv = chv; v.amt = amt; v.cred = cred; v.busy = b; v.crdy = crdy;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // product 1 paid exactly with 2+2+1, no change
    vecs.push_back(mk(0,1,1,0,0,0,0,0, 0,0,0,0,0,1,1));
    vecs.push_back(mk(0,0,0,1,2,0,0,0, 0,0,0,0,2,1,1));
    vecs.push_back(mk(0,0,0,1,2,0,0,0, 0,0,0,0,4,1,1));
    vecs.push_back(mk(0,0,0,1,1,0,0,0, 1,1,0,0,5,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,1,0,0,5,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,0, 0,0,0,0,0,0,0));
    // product 0 with a 7 coin: change 4 held through 5 unacked cycles with noise on ignored inputs
    vecs.push_back(mk(0,1,0,0,0,0,0,0, 0,0,0,0,0,1,1));
    vecs.push_back(mk(0,0,0,1,7,0,0,0, 1,0,0,0,7,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,0, 0,0,1,4,7,1,0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0,1,3,1,5,1,1,0, 0,0,1,4,7,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0));
    // product 3, coin 2, then cancel with coin 3 -> refund 5
    vecs.push_back(mk(0,1,3,0,0,0,0,0, 0,0,0,0,0,1,1));
    vecs.push_back(mk(0,0,0,1,2,0,0,0, 0,0,0,0,2,1,1));
    vecs.push_back(mk(0,0,0,1,3,1,0,0, 0,0,1,5,5,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,1,7,1,1,1, 0,0,0,0,0,0,0));
    // reset while dispensing abandons the sale
    vecs.push_back(mk(0,1,2,0,0,0,0,0, 0,0,0,0,0,1,1));
    vecs.push_back(mk(0,0,0,1,7,0,0,0, 1,2,0,0,7,1,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,1, 0,0,0,0,0,0,0));
    // cancel with no credit, and cancel overriding a reached price
    vecs.push_back(mk(0,1,0,0,0,0,0,0, 0,0,0,0,0,1,1));
    vecs.push_back(mk(0,0,0,0,0,1,0,0, 0,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,0, 0,0,0,0,0,1,1));
    vecs.push_back(mk(0,0,0,1,5,1,0,0, 0,0,1,5,5,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0));

    apply(1,0,0,0,0,0,0,0);
    apply(1,0,0,0,0,0,0,0);
    chk("rst_disp", 32'(dispense), 32'd0);
    chk("rst_id", 32'(dispense_id), 32'd0);
    chk("rst_chv", 32'(change_valid), 32'd0);
    chk("rst_amt", 32'(change_amt), 32'd0);
    chk("rst_credit", 32'(credit), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_crdy", 32'(coin_ready), 32'd0);
    chk("rst_sales", sales_cnt, 32'd0);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].pv, vecs[i].prod, vecs[i].cv, vecs[i].cval,
            vecs[i].cn, vecs[i].dr, vecs[i].ca);
      chk($sformatf("vec%0d_disp", i), 32'(dispense), 32'(vecs[i].disp));
      if (vecs[i].disp || vecs[i].rst) chk($sformatf("vec%0d_id", i), 32'(dispense_id), 32'(vecs[i].id));
      chk($sformatf("vec%0d_chv", i), 32'(change_valid), 32'(vecs[i].chv));
      if (vecs[i].chv || vecs[i].rst) chk($sformatf("vec%0d_amt", i), 32'(change_amt), 32'(vecs[i].amt));
      chk($sformatf("vec%0d_credit", i), 32'(credit), 32'(vecs[i].cred));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("vec%0d_crdy", i), 32'(coin_ready), 32'(vecs[i].crdy));
    end

    // timeout: refund exactly TO cycles after the last real coin; a zero coin does not restart it
    apply(0,1,2,0,0,0,0,0);
    apply(0,0,0,1,1,0,0,0);
    for (int k = 1; k <= TO; k++) begin
      apply(0,0,0,(k == 3),0,0,0,0);
      chk($sformatf("timeout_k%0d_chv", k), 32'(change_valid), 32'(k == TO));
    end
    chk("timeout_amt", 32'(change_amt), 32'd1);
    check_all("timeout");
    apply(0,0,0,0,0,0,0,1);
    check_all("timeout_done");

    // 256 sales of product 2 saturate its counter
    apply(1,0,0,0,0,0,0,0);
    for (int n = 0; n < 256; n++) begin
      apply(0,1,2,0,0,0,0,0);
      apply(0,0,0,1,6,0,0,0);
      apply(0,0,0,0,0,0,1,0);
    end
`ifdef VEND_SESSION_CTRL_SALES_CNT_EN
    chk("sales_prod2", 32'(sales_cnt[23:16]), 32'd255);
`else
    chk("sales_prod2", 32'(sales_cnt[23:16]), 32'd0);
`endif
    check_all("sales");

    for (int n = 0; n < 3000; n++) begin
      apply(($urandom_range(199) == 0), ($urandom_range(3) == 0), 2'($urandom_range(3)),
            ($urandom_range(1) == 0), 3'($urandom_range(7)), ($urandom_range(15) == 0),
            ($urandom_range(2) == 0), ($urandom_range(2) == 0));
      check_all($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vend_session_ctrl.md
VEND_SESSION_CTRL -- requirements
Module: vend_session_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 1000, idle cycles allowed in COLLECT before auto-refund (legal range 2..65535).
REQ-002 clk  input  1  system clock, all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 product_valid  input  1  product selection strobe, sampled in IDLE only.
REQ-005 product  input  2  product code: 0=15, 1=25, 2=30, 3=35 (price units of 5: 3, 5, 6, 7).
REQ-006 coin_valid  input  1  coin present this cycle.
REQ-007 coin_val  input  3  coin value in units of 5 (0..7).
REQ-008 coin_ready  output  1  high only in COLLECT; a coin is accepted when coin_valid && coin_ready.
REQ-009 cancel  input  1  customer abort, effective in COLLECT only.
REQ-010 dispense  output  1  dispense request, held until accepted.
REQ-011 dispense_id  output  2  product code being dispensed; valid while dispense=1.
REQ-012 dispense_ready  input  1  dispenser accepts the request when dispense && dispense_ready.
REQ-013 change_valid  output  1  change/refund request, held until acknowledged.
REQ-014 change_amt  output  4  change amount in units of 5; stable while change_valid=1.
REQ-015 change_ack  input  1  coin return accepts when change_valid && change_ack.
REQ-016 credit  output  4  current accumulated credit in units of 5.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 sales_cnt  output  32  four packed 8-bit per-product counters, product n at bits [8n+7:8n].

Function
REQ-019 FSM states: IDLE, COLLECT, DISPENSE, CHANGE; all outputs registered.
REQ-020 IDLE: on product_valid, latch product into sel and go to COLLECT next cycle with credit=0, timer=0.
REQ-021 COLLECT: an accepted coin with coin_val!=0 adds coin_val to credit; coin_val=0 is ignored and does not restart the timer.
REQ-022 COLLECT: when the updated credit >= price(sel), go to DISPENSE the next cycle; dispense and dispense_id become visible in that cycle.
REQ-023 Credit never exceeds 13 (max 6+7), so the 4-bit width cannot overflow; no saturation logic.
REQ-024 DISPENSE: hold dispense=1 until the handshake completes; then change_amt=credit-price(sel). If nonzero, go to CHANGE; otherwise go to IDLE with credit=0.
REQ-025 CHANGE: hold change_valid=1 and change_amt until the handshake completes, then go to IDLE with credit=0.
REQ-026 Cancel in COLLECT: go to CHANGE with change_amt=credit. A coin accepted in the same cycle is included in the refund, and cancel overrides price reached. If credit (including that coin) is 0, go directly to IDLE.
REQ-027 Timer: counts cycles in COLLECT and clears on each nonzero accepted coin. When it reaches TIMEOUT_CYC-1 with no coin that cycle, apply the cancel behaviour.
REQ-028 In IDLE, DISPENSE and CHANGE, coin_valid, cancel and product_valid are ignored.
REQ-029 At most one handshake completes per cycle; DISPENSE always completes before CHANGE.

Reset
REQ-030 rst=1 at a clock edge forces IDLE and clears credit, sel and timer on that edge.
REQ-031 The same reset edge forces dispense=0, dispense_id=0, change_valid=0, change_amt=0, coin_ready=0, busy=0 and sales_cnt=0.
REQ-032 Reset mid-transaction abandons it: no dispense and no refund is issued afterwards.

Configuration
REQ-033 Macro VEND_SESSION_CTRL_SALES_CNT_EN. When defined, each completed dispense handshake increments the 8-bit counter of dispense_id, saturating at 255. When undefined, sales_cnt is constant 0 and no counter flops exist.

Verification
REQ-034 Bench: product=1, coins 2, 2, 1 -> dispense, dispense_id=1, credit=5, no change_valid, back to IDLE.
REQ-035 Bench: product=0, coin 7 -> dispense, then change_valid with change_amt=4; change_ack held low for 5 cycles -> change_valid and change_amt stable throughout.
REQ-036 Bench: product=3, coin 2, then cancel together with coin 3 -> no dispense, change_amt=5.
REQ-037 Bench: TIMEOUT_CYC=8, product=2, coin 1, no further coins -> refund change_amt=1 exactly 8 cycles after the coin.
REQ-038 Bench: rst asserted while dispense=1 -> next cycle IDLE with all outputs 0; no change issued.
REQ-039 Bench: macro defined, 256 sales of product 2 -> sales_cnt[23:16]=255. Macro undefined -> sales_cnt stays 0.
